i_delay_tap_ctrl: RTL and testbench

Command-driven tap controller for one I_DELAY input-delay primitive. It sits directly upstream of the delay cell and drives its DLY_LOAD, DLY_ADJ and DLY_INCDEC inputs. It reads back DLY_TAP_VALUE and steps the tap one increment or decrement at a time until it equals a requested target (0-63), or issues a single load pulse. It reports completion, step count and stall errors to the calibration logic above it.

---
 rtl/i_delay_tap_ctrl.sv | 135 +++++++++++++
 tb/tb_i_delay_tap_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i_delay_tap_ctrl.sv
// Tap controller for one I_DELAY cell: steps the tap one adjust pulse at a time
// until read-back matches a target, or issues a single load pulse.
module i_delay_tap_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_load,
  input  logic [5:0] cmd_target,
  input  logic [5:0] dly_tap_value,
  output logic       dly_load,
  output logic       dly_adj,
  output logic       dly_incdec,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [5:0] step_count
);
  localparam int unsigned TAP_W = 6;
  localparam int unsigned CNT_W = 4;

  if (SETTLE_CYCLES < 2 || SETTLE_CYCLES > 15) begin : g_settle_range
    $fatal(1, "i_delay_tap_ctrl: SETTLE_CYCLES=%0d outside 2..15", SETTLE_CYCLES);
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ADJ,
    S_WAIT,
    S_LOAD,
    S_DONE
  } state_t;

  state_t           state;
  logic [TAP_W-1:0] target;
  logic [TAP_W-1:0] prev_tap;
  logic             stepped;
  logic             load_flag;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_last;

  // A load re-seeds the whole tap register, so it gets one extra settle cycle.
  assign wait_last = load_flag ? CNT_W'(SETTLE_CYCLES) : CNT_W'(SETTLE_CYCLES - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cmd_ready  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      dly_load   <= 1'b0;
      dly_adj    <= 1'b0;
      dly_incdec <= 1'b0;
      step_count <= '0;
      target     <= '0;
      prev_tap   <= '0;
      stepped    <= 1'b0;
      load_flag  <= 1'b0;
      wait_cnt   <= '0;
    end else begin
      // Pulse outputs are high for one cycle only unless re-asserted below.
      dly_load <= 1'b0;
      dly_adj  <= 1'b0;
      done     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            target     <= cmd_target;
            step_count <= '0;
            err        <= 1'b0;
            stepped    <= 1'b0;
            load_flag  <= cmd_load;
            cmd_ready  <= 1'b0;
            busy       <= 1'b1;
            if (cmd_load) begin
              dly_load <= 1'b1;
              state    <= S_LOAD;
            end else begin
              state <= S_CHECK;
            end
          end
        end
        S_CHECK: begin
          if (dly_tap_value == target) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else if (stepped && (dly_tap_value == prev_tap)) begin
            // Last adjust did not move the tap: report a stall.
            done  <= 1'b1;
            err   <= 1'b1;
            state <= S_DONE;
          end else begin
            dly_incdec <= (target > dly_tap_value);
            prev_tap   <= dly_tap_value;
            stepped    <= 1'b1;
            step_count <= step_count + TAP_W'(1);
            dly_adj    <= 1'b1;
            state      <= S_ADJ;
          end
        end
        S_ADJ, S_LOAD: begin
          wait_cnt <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt == wait_last) begin
            if (load_flag) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              state <= S_CHECK;
            end
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
        default: begin
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i_delay_tap_ctrl.sv
// Directed bench for i_delay_tap_ctrl: a delay-cell model plus a scoreboard of
// expected command completions checked by an independent monitor.
module tb_i_delay_tap_ctrl;
  localparam int unsigned SETTLE = 3;
  localparam int          PERIOD = int'(SETTLE) + 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_load = 1'b0;
  logic [5:0] cmd_target = 6'd0;
  logic [5:0] dly_tap_value;
  logic       dly_load;
  logic       dly_adj;
  logic       dly_incdec;
  logic       busy;
  logic       done;
  logic       err;
  logic [5:0] step_count;

  i_delay_tap_ctrl #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_load     (cmd_load),
    .cmd_target   (cmd_target),
    .dly_tap_value(dly_tap_value),
    .dly_load     (dly_load),
    .dly_adj      (dly_adj),
    .dly_incdec   (dly_incdec),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .step_count   (step_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Delay-cell model: an adjust or load in cycle c is visible from cycle c+2.
  logic [5:0] cell_tap = 6'd0;
  logic [5:0] cell_delay = 6'd20;
  logic       adj_q = 1'b0;
  logic       inc_q = 1'b0;
  logic       load_q = 1'b0;
  logic       freeze = 1'b0;
  logic       tb_set = 1'b1;
  logic [5:0] tb_val = 6'd10;

  always @(posedge clk) begin
    adj_q  <= dly_adj;
    inc_q  <= dly_incdec;
    load_q <= dly_load;
    if (tb_set) cell_tap <= tb_val;
    else if (load_q) cell_tap <= cell_delay;
    else if (adj_q && !freeze) cell_tap <= inc_q ? cell_tap + 6'd1 : cell_tap - 6'd1;
  end
  assign dly_tap_value = cell_tap;

  typedef struct {
    string name;
    int    err;
    int    steps;
    int    tap;
    int    lat;
    int    adj_n;
    int    load_n;
    int    dir;
    int    acc_edge;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for the DUT", name);
  endtask

  // Monitor: pulse rules, direction, spacing, and scoreboard pop on done.
  int adj_cnt = 0;
  int load_cnt = 0;
  int low_run = 100;
  int last_adj = -1;

  always @(negedge clk) begin
    exp_t e;
    if (rst) last_adj = -1;
    if (cmd_valid && cmd_ready && !rst) begin
      adj_cnt  = 0;
      load_cnt = 0;
      last_adj = -1;
    end
    if (dly_adj || dly_load) begin
      chk("pulse_exclusive", int'(dly_adj && dly_load), 0);
      chk("pulse_low_gap_ge2", int'(low_run >= 2), 1);
      if (dly_load) load_cnt++;
      if (dly_adj) begin
        adj_cnt++;
        if (exp_q.size() != 0) chk({exp_q[0].name, "_incdec"}, int'(dly_incdec), exp_q[0].dir);
        if (last_adj >= 0) chk("adj_spacing", edge_cnt - last_adj, PERIOD);
        last_adj = edge_cnt;
      end
      low_run = 0;
    end else if (low_run < 100) begin
      low_run++;
    end
    if (done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no completion");
      end else begin
        e = exp_q.pop_front();
        chk({e.name, "_err"}, int'(err), e.err);
        chk({e.name, "_steps"}, int'(step_count), e.steps);
        chk({e.name, "_tap"}, int'(dly_tap_value), e.tap);
        chk({e.name, "_latency"}, edge_cnt - e.acc_edge, e.lat);
        chk({e.name, "_adj_pulses"}, adj_cnt, e.adj_n);
        chk({e.name, "_load_pulses"}, load_cnt, e.load_n);
      end
    end
  end

  task automatic set_tap(input logic [5:0] v);
    tb_set = 1'b1;
    tb_val = v;
    @(posedge clk); #2;
    tb_set = 1'b0;
  endtask

  task automatic issue(input string name, input bit ld, input int tgt, input bit push,
                       input int err_e, input int steps_e, input int tap_e, input int lat_e,
                       input int adj_e, input int load_e, input int dir_e);
    exp_t e;
    int guard;
    cmd_load   = ld;
    cmd_target = 6'(tgt);
    cmd_valid  = 1'b1;
    guard = 0;
    while (!(cmd_ready && !rst) && guard < 1000) begin
      @(posedge clk); #2;
      guard++;
    end
    if (!(cmd_ready && !rst)) begin
      timeout_fail({name, "_accept"});
    end else if (push) begin
      e.name = name; e.err = err_e; e.steps = steps_e; e.tap = tap_e; e.lat = lat_e;
      e.adj_n = adj_e; e.load_n = load_e; e.dir = dir_e; e.acc_edge = edge_cnt + 1;
      exp_q.push_back(e);
    end
    @(posedge clk); #2;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      timeout_fail({name, "_done"});
      exp_q.delete();
    end
    @(posedge clk); #2;
  endtask

  function automatic int out_vec();
    return int'({cmd_ready, busy, done, err, dly_load, dly_adj, dly_incdec});
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n_steps;
    // Reset held with a pending request: outputs at reset values, no accept.
    cmd_valid  = 1'b1;
    cmd_target = 6'd10;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      chk("reset_outputs", out_vec(), 7'b1000000);
      chk("reset_step_count", int'(step_count), 0);
    end
    tb_set = 1'b0;
    rst    = 1'b0;
    issue("first_after_reset", 1'b0, 10, 1'b1, 0, 0, 10, 1, 0, 0, 1);
    wait_idle("first_after_reset", 50);

    issue("seek_10_to_15", 1'b0, 15, 1'b1, 0, 5, 15, 26, 5, 0, 1);
    wait_idle("seek_10_to_15", 100);

    set_tap(6'd63);
    issue("seek_63_to_0", 1'b0, 0, 1'b1, 0, 63, 0, 316, 63, 0, 0);
    wait_idle("seek_63_to_0", 500);

    set_tap(6'd63);
    issue("seek_63_to_63", 1'b0, 63, 1'b1, 0, 0, 63, 1, 0, 0, 0);
    wait_idle("seek_63_to_63", 50);

    cell_delay = 6'd20;
    issue("load_20", 1'b1, 0, 1'b1, 0, 0, 20, 5, 0, 1, 0);
    wait_idle("load_20", 50);

    freeze = 1'b1;
    set_tap(6'd30);
    issue("stall_30_to_40", 1'b0, 40, 1'b1, 1, 1, 30, 6, 1, 0, 1);
    wait_idle("stall_30_to_40", 100);
    freeze = 1'b0;

    // Reset in the middle of a 10-step seek, during the first settle wait.
    set_tap(6'd5);
    issue("aborted_seek", 1'b0, 15, 1'b0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #2;
    @(posedge clk); #2;
    chk("abort_busy_before_reset", int'(busy), 1);
    rst = 1'b1;
    #1;
    chk("abort_reset_outputs", out_vec(), 7'b1000000);
    chk("abort_reset_step_count", int'(step_count), 0);
    repeat (2) begin @(posedge clk); #2; end
    rst = 1'b0;
    repeat (3) begin @(posedge clk); #2; end
    n_steps = 15 - int'(cell_tap);
    issue("seek_after_reset", 1'b0, 15, 1'b1, 0, n_steps, 15, 1 + n_steps * PERIOD, n_steps, 0, 1);
    wait_idle("seek_after_reset", 200);

    // Requests raised while busy must be ignored.
    issue("seek_15_to_20", 1'b0, 20, 1'b1, 0, 5, 20, 26, 5, 0, 1);
    for (int k = 0; k < 3; k++) begin
      repeat (3) begin @(posedge clk); #2; end
      cmd_valid  = 1'b1;
      cmd_load   = 1'b1;
      cmd_target = 6'd0;
      @(posedge clk); #2;
      cmd_valid = 1'b0;
      chk("busy_request_ignored", int'(busy), 1);
    end
    wait_idle("seek_15_to_20", 100);

    repeat (10) begin @(posedge clk); #2; end
    chk("final_idle_ready", int'(cmd_ready), 1);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
